// File: rtl/systolic_pkg.sv
// Constants shared by the systolic-array feeder and result packer.
// Both ends agree that byte order is MSB first: the first byte of a word lands in [WW-1:WW-BW].
package systolic_pkg;
   localparam int BW    = 8;
   localparam int NB    = 4;
   localparam int WW    = BW * NB;
   localparam int LANES = 4;

   // Shift a word left by nsh whole bytes, zero-filling the low end.
   function automatic logic [WW-1:0] left_justify(input logic [WW-1:0] w, input logic [1:0] nsh);
      return w << (BW * nsh);
   endfunction
endpackage

// File: rtl/pack_lane.sv
// One lane of the result packer: a byte shift register feeding a one-word output slot.
// The common counter and handshake control live in result_pack.
module pack_lane
   import systolic_pkg::*;
(
   input  logic          clk,
   input  logic          rstn,
   input  logic          i_shift,
   input  logic          i_load,
   input  logic          i_use_beat,
   input  logic [1:0]    i_lsh,
   input  logic [BW-1:0] i_din,
   output logic [WW-1:0] o_dout
);
   // Only NB-1 bytes are ever held: the NBth byte goes straight to the slot.
   logic [(NB-1)*BW-1:0] r_pack;
   logic [WW-1:0]        r_slot;
   logic [WW-1:0]        w_next;
   logic [WW-1:0]        w_src;

   assign w_next = {r_pack, i_din};
   assign w_src  = i_use_beat ? w_next : {{BW{1'b0}}, r_pack};
   assign o_dout = r_slot;

   // Shift the accepted byte in at the LSB end; stale upper bytes drop off during justification.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)        r_pack <= '0;
      else if (i_shift) r_pack <= w_next[(NB-1)*BW-1:0];
   end

   // Output slot holds the MSB-aligned word until the control reloads it.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)       r_slot <= '0;
      else if (i_load) r_slot <= left_justify(w_src, i_lsh);
   end
endmodule

// File: rtl/result_pack.sv
// Receive edge of the systolic array: packs four consecutive bytes per lane into a
// 32-bit word, with valid/ready on both sides and flush of partial words.
module result_pack
   import systolic_pkg::*;
(
   input  logic          clk,
   input  logic          rstn,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [BW-1:0] dinA,
   input  logic [BW-1:0] dinB,
   input  logic [BW-1:0] dinC,
   input  logic [BW-1:0] dinD,
   input  logic          flush,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [WW-1:0] doutA,
   output logic [WW-1:0] doutB,
   output logic [WW-1:0] doutC,
   output logic [WW-1:0] doutD,
   output logic [2:0]    out_nbytes,
   output logic          ovf
);
   logic [1:0] r_cnt;
   logic       r_pend;
   logic       r_valid;
   logic [2:0] r_nbytes;
   logic       r_ovf;

   logic       w_slot_free;
   logic       w_acc;
   logic       w_full;
   logic       w_pf_beat;
   logic       w_pf_idle;
   logic       w_load;
   logic [1:0] w_lsh;
   logic [2:0] w_nb;

   assign w_slot_free = !r_valid || out_ready;
   // A pending flush owns the packer until it lands; otherwise only the completing beat stalls.
   assign in_ready    = !r_pend && !((r_cnt == 2'd3) && !w_slot_free);
   assign w_acc       = in_valid && in_ready;
   assign w_full      = w_acc && (r_cnt == 2'd3);
   assign w_pf_beat   = w_acc && (r_cnt != 2'd3) && flush;
   assign w_pf_idle   = !w_acc && (flush || r_pend) && (r_cnt != 2'd0);
   assign w_load      = w_full || ((w_pf_beat || w_pf_idle) && w_slot_free);

   // Justification shift and byte count for whatever is being moved into the slot.
   always_comb begin
      w_lsh = 2'd0;
      w_nb  = 3'd4;
      if (w_pf_beat) begin
         w_lsh = 2'd3 - r_cnt;
         w_nb  = {1'b0, r_cnt} + 3'd1;
      end else if (w_pf_idle) begin
         w_lsh = 2'(3'd4 - {1'b0, r_cnt});
         w_nb  = {1'b0, r_cnt};
      end
   end

   // Shared byte counter, flush-pending flag, slot valid and byte count.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_cnt    <= 2'd0;
         r_pend   <= 1'b0;
         r_valid  <= 1'b0;
         r_nbytes <= 3'd0;
      end else begin
         r_pend <= (w_pf_beat || w_pf_idle) && !w_slot_free;
         if (w_load)     r_cnt <= 2'd0;
         else if (w_acc) r_cnt <= r_cnt + 2'd1;
         if (w_load) begin
            r_valid  <= 1'b1;
            r_nbytes <= w_nb;
         end else if (out_ready) begin
            r_valid  <= 1'b0;
         end
      end
   end

   // Sticky overflow: a dropped beat, or a flush that has nothing to close while the slot is full.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_ovf <= 1'b0;
      else if ((in_valid && !in_ready) ||
               (flush && !w_acc && (r_cnt == 2'd0) && !w_slot_free))
         r_ovf <= 1'b1;
   end

   assign out_valid  = r_valid;
   assign out_nbytes = r_nbytes;
   assign ovf        = r_ovf;

   pack_lane u_lane_a (.clk(clk), .rstn(rstn), .i_shift(w_acc), .i_load(w_load), .i_use_beat(w_acc),
                       .i_lsh(w_lsh), .i_din(dinA), .o_dout(doutA));
   pack_lane u_lane_b (.clk(clk), .rstn(rstn), .i_shift(w_acc), .i_load(w_load), .i_use_beat(w_acc),
                       .i_lsh(w_lsh), .i_din(dinB), .o_dout(doutB));
   pack_lane u_lane_c (.clk(clk), .rstn(rstn), .i_shift(w_acc), .i_load(w_load), .i_use_beat(w_acc),
                       .i_lsh(w_lsh), .i_din(dinC), .o_dout(doutC));
   pack_lane u_lane_d (.clk(clk), .rstn(rstn), .i_shift(w_acc), .i_load(w_load), .i_use_beat(w_acc),
                       .i_lsh(w_lsh), .i_din(dinD), .o_dout(doutD));
endmodule

// File: tb/tb_result_pack.sv
// Bench for result_pack: vector table for the streaming cases, hand sequences for
// back-pressure, blocked flush, reset mid-word and overflow; words checked via a scoreboard.
module tb_result_pack;
   import systolic_pkg::*;

   logic          clk, rstn, in_valid, in_ready, flush, out_valid, out_ready, ovf;
   logic [BW-1:0] dinA, dinB, dinC, dinD;
   logic [WW-1:0] doutA, doutB, doutC, doutD;
   logic [2:0]    out_nbytes;

   result_pack dut (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
      .dinA(dinA), .dinB(dinB), .dinC(dinC), .dinD(dinD), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .doutA(doutA), .doutB(doutB), .doutC(doutC), .doutD(doutD),
      .out_nbytes(out_nbytes), .ovf(ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        v, f, r;
      logic [7:0]  a;
      logic        rdy, ov, push;
      logic [31:0] w;
      logic [2:0]  nb;
   } vec_t;

   typedef struct {
      logic [31:0] a, b, c, d;
      logic [2:0]  nb;
   } exp_t;

   vec_t tbl[$];
   exp_t sbq[$];
   exp_t mon_e;
   int   errors = 0;
   int   checks = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Lane k carries lane A's bytes plus k; zero-filled bytes stay zero.
   function automatic logic [31:0] inc(input logic [31:0] w, input int k, input logic [2:0] nb);
      logic [31:0] r;
      r = w;
      for (int i = 0; i < 4; i++)
         if (i < int'(nb)) r[31-8*i -: 8] = w[31-8*i -: 8] + 8'(k);
      return r;
   endfunction

   task automatic push_exp(input logic [31:0] w, input logic [2:0] nb);
      sbq.push_back('{w, inc(w, 1, nb), inc(w, 2, nb), inc(w, 3, nb), nb});
   endtask

   task automatic add(input logic v, f, r, input logic [7:0] a, input logic rdy, ov,
                      input logic push, input logic [31:0] w, input logic [2:0] nb);
      tbl.push_back('{v, f, r, a, rdy, ov, push, w, nb});
   endtask

   // One clock: drive after the edge, check handshake at the falling edge.
   task automatic cyc(input logic v, f, r, input logic [7:0] a, input logic erdy, eov);
      in_valid = v; flush = f; out_ready = r;
      dinA = a; dinB = a + 8'd1; dinC = a + 8'd2; dinD = a + 8'd3;
      @(negedge clk);
      chk("in_ready", 32'(in_ready), 32'(erdy));
      chk("out_valid", 32'(out_valid), 32'(eov));
      @(posedge clk); #1;
   endtask

   // Scoreboard: every word taken by the consumer must match the next expected word.
   always @(negedge clk) begin
      if (rstn && out_valid && out_ready) begin
         if (sbq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_word: got %h want none", doutA);
         end else begin
            mon_e = sbq.pop_front();
            chk("word_A", doutA, mon_e.a);
            chk("word_B", doutB, mon_e.b);
            chk("word_C", doutC, mon_e.c);
            chk("word_D", doutD, mon_e.d);
            chk("nbytes", 32'(out_nbytes), 32'(mon_e.nb));
         end
      end
   end

   initial begin
      clk = 0; rstn = 0; in_valid = 0; flush = 0; out_ready = 0;
      dinA = 0; dinB = 0; dinC = 0; dinD = 0;
      #12;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_ovf", 32'(ovf), 0);
      chk("rst_doutA", doutA, 0);
      chk("rst_nbytes", 32'(out_nbytes), 0);
      @(posedge clk); #1; rstn = 1;

      // basic pack
      add(1,0,1,8'h11,1,0,0,0,0);
      add(1,0,1,8'h22,1,0,0,0,0);
      add(1,0,1,8'h33,1,0,0,0,0);
      add(1,0,1,8'h44,1,0,1,32'h11223344,4);
      add(0,0,1,8'h00,1,1,0,0,0);
      add(0,0,1,8'h00,1,0,0,0,0);
      // back-to-back 12 beats
      for (int i = 0; i < 12; i++)
         add(1,0,1,8'(8'h50+i),1,(i==4||i==8),(i%4==3),
             {8'(8'h50+i-3),8'(8'h50+i-2),8'(8'h50+i-1),8'(8'h50+i)},4);
      add(0,0,1,8'h00,1,1,0,0,0);
      // partial flush
      add(1,0,1,8'h01,1,0,0,0,0);
      add(1,0,1,8'h02,1,0,0,0,0);
      add(0,1,1,8'h00,1,0,1,32'h01020000,2);
      add(0,0,1,8'h00,1,1,0,0,0);
      // flush on the 4th beat
      add(1,0,1,8'h61,1,0,0,0,0);
      add(1,0,1,8'h62,1,0,0,0,0);
      add(1,0,1,8'h63,1,0,0,0,0);
      add(1,1,1,8'h64,1,0,1,32'h61626364,4);
      add(0,0,1,8'h00,1,1,0,0,0);
      add(0,0,1,8'h00,1,0,0,0,0);
      // flush with the first beat
      add(1,1,1,8'h70,1,0,1,32'h70000000,1);
      add(0,0,1,8'h00,1,1,0,0,0);
      add(0,0,1,8'h00,1,0,0,0,0);

      foreach (tbl[i]) begin
         if (tbl[i].push) push_exp(tbl[i].w, tbl[i].nb);
         cyc(tbl[i].v, tbl[i].f, tbl[i].r, tbl[i].a, tbl[i].rdy, tbl[i].ov);
      end

      // back-pressure: 8 beats with the consumer stalled
      cyc(1,0,0,8'hAA,1,0); cyc(1,0,0,8'hAB,1,0); cyc(1,0,0,8'hAC,1,0);
      push_exp(32'hAAABACAD, 4);
      cyc(1,0,0,8'hAD,1,0);
      cyc(1,0,0,8'hAE,1,1); cyc(1,0,0,8'hAF,1,1); cyc(1,0,0,8'hB0,1,1);
      cyc(0,0,0,8'hB1,0,1);
      chk("bp_hold", doutA, 32'hAAABACAD);
      push_exp(32'hAEAFB0B1, 4);
      cyc(1,0,1,8'hB1,1,1);
      cyc(0,0,1,8'h00,1,1);
      cyc(0,0,1,8'h00,1,0);
      chk("bp_ovf", 32'(ovf), 0);

      // blocked flush
      cyc(1,0,0,8'hC0,1,0); cyc(1,0,0,8'hC1,1,0); cyc(1,0,0,8'hC2,1,0);
      push_exp(32'hC0C1C2C3, 4);
      cyc(1,0,0,8'hC3,1,0);
      cyc(1,0,0,8'hC4,1,1); cyc(1,0,0,8'hC5,1,1); cyc(1,0,0,8'hC6,1,1);
      push_exp(32'hC4C5C600, 3);
      cyc(0,1,0,8'h00,0,1);
      cyc(0,0,0,8'h00,0,1);
      cyc(0,0,1,8'h00,0,1);
      chk("bf_nbytes", 32'(out_nbytes), 3);
      cyc(0,0,1,8'h00,1,1);
      cyc(0,0,1,8'h00,1,0);

      // reset mid-word with a full slot and cnt=2
      cyc(1,0,0,8'hE0,1,0); cyc(1,0,0,8'hE1,1,0); cyc(1,0,0,8'hE2,1,0); cyc(1,0,0,8'hE3,1,0);
      cyc(1,0,0,8'hE4,1,1); cyc(1,0,0,8'hE5,1,1);
      in_valid = 0; flush = 0; out_ready = 0;
      rstn = 0; #1;
      chk("mr_out_valid", 32'(out_valid), 0);
      chk("mr_doutA", doutA, 0);
      chk("mr_doutD", doutD, 0);
      chk("mr_nbytes", 32'(out_nbytes), 0);
      chk("mr_in_ready", 32'(in_ready), 1);
      @(posedge clk); @(posedge clk); #1; rstn = 1;
      cyc(1,0,1,8'hF0,1,0); cyc(1,0,1,8'hF1,1,0); cyc(1,0,1,8'hF2,1,0);
      push_exp(32'hF0F1F2F3, 4);
      cyc(1,0,1,8'hF3,1,0);
      cyc(0,0,1,8'h00,1,1);
      cyc(0,0,1,8'h00,1,0);

      // overflow: beat presented while stalled
      cyc(1,0,0,8'hD0,1,0); cyc(1,0,0,8'hD1,1,0); cyc(1,0,0,8'hD2,1,0);
      push_exp(32'hD0D1D2D3, 4);
      cyc(1,0,0,8'hD3,1,0);
      cyc(1,0,0,8'hD4,1,1); cyc(1,0,0,8'hD5,1,1); cyc(1,0,0,8'hD6,1,1);
      chk("ovf_before", 32'(ovf), 0);
      cyc(1,0,0,8'hD7,0,1);
      chk("ovf_set", 32'(ovf), 1);
      cyc(0,0,1,8'h00,1,1);
      push_exp(32'hD4D5D600, 3);
      cyc(0,1,1,8'h00,1,0);
      cyc(0,0,1,8'h00,1,1);
      cyc(0,0,1,8'h00,1,0);
      chk("ovf_sticky", 32'(ovf), 1);

      // bounded drain of anything still expected
      for (int i = 0; i < 20 && sbq.size() != 0; i++) begin
         in_valid = 0; flush = 0; out_ready = 1;
         @(posedge clk); #1;
      end
      chk("sb_empty", 32'(sbq.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/result_pack.md
Name: result_pack

Overview:
- Receive end of the systolic-array weight/data byte stream: collects one 8-bit result per lane per cycle on four lanes (A-D) and packs every four consecutive bytes, MSB first, into one 32-bit word per lane.
- Sits between the array output edge and the bus/SRAM write port.
- Drains the array in the same byte order the feeder loads it, first byte landing in [31:24].
- Double-buffered (packing register plus output holding register) with valid/ready back-pressure on both sides.

Parameters:
- BW, 8, byte width per lane.
- NB, 4, bytes per packed word; word width = BW*NB = 32.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- in_valid  in  1  dinA..dinD carry one valid byte each this cycle.
- in_ready  out  1  block can accept a byte beat this cycle.
- dinA, dinB, dinC, dinD  in  8 each  lane result bytes.
- flush  in  1  one-cycle pulse: close the current partial word, zero-filling the missing low bytes.
- out_valid  out  1  doutA..doutD hold a complete word.
- out_ready  in  1  consumer takes the word this cycle.
- doutA, doutB, doutC, doutD  out  32 each  packed words.
- out_nbytes  out  3  valid byte count in the presented word (1..4), MSB-aligned.
- ovf  out  1  sticky: beat presented while in_ready=0, or flush with an empty packer and a full slot; cleared only by reset.

Behaviour:
- Reset (async, rstn=0), values held immediately:
  - All pack registers, dout*, out_nbytes, cnt, ovf = 0.
  - out_valid = 0; in_ready = 1.
  - Reset mid-word discards the partial data.
- Input beat accepted when in_valid && in_ready.
  - Each lane shifts left by BW: pack <= {pack[23:0], din}.
  - cnt (0..3) increments.
- Word completion on the 4th accepted beat (cnt==3):
  - The combined value {pack[23:0], din} transfers to the output slot.
  - out_valid=1, out_nbytes=4 on the next cycle; cnt wraps to 0.
  - Latency: last byte in at edge N, word visible after edge N.
- Output slot handshake:
  - The word is held stable while out_valid && !out_ready.
  - out_valid drops after the edge where out_ready=1, unless a new word loads on the same edge.
  - Simultaneous drain and load: the slot reloads and out_valid stays 1, with no bubble.
- in_ready = !(cnt==3 && out_valid && !out_ready).
  - Only the completing beat can stall.
  - Combinational from out_ready; this is the only combinational path.
- flush with cnt>0 and no accepted beat:
  - Left-justify the partial word: pack << (BW*(NB-cnt)), zero-filled.
  - Move it to the slot with out_nbytes=cnt; cnt -> 0.
  - Needs the slot free (same stall rule); if blocked, flush is held pending internally until the slot frees.
- flush in the same cycle as an accepted beat:
  - The beat is included first.
  - If that makes 4 bytes, a normal full word is produced and no extra empty word follows.
- flush with cnt==0 and nothing pending: no effect.
- in_valid while in_ready=0: byte dropped, ovf set.
- Pending flush also deasserts in_ready until it completes.

Decomposition:
- Shared package (systolic_pkg):
  - BW, NB, and the word-width constant.
  - Lane count 4.
  - Shared with the weight feeder so both ends agree on byte order (MSB first).
- One natural sub-module: pack_lane.
  - Single-lane shift/pack register plus output slot.
  - Instantiated 4 times.
  - Common cnt/handshake control in the top.

Test Plan:
- Basic pack:
  - Stimulus: 4 beats, A=11,22,33,44 (B..D = A+1..A+3 bytewise), out_ready=1.
  - Response: after the 4th edge doutA=0x11223344, doutB=0x12233445, out_nbytes=4, out_valid for one cycle.
- Back-pressure:
  - Stimulus: out_ready=0, stream 8 beats (AA..B1).
  - Response: first word 0xAAABACAD held; in_ready=0 at beat 8; after out_ready=1, 0xAEAFB0B1 follows with no loss; ovf=0.
- Back-to-back:
  - Stimulus: continuous 12 beats with out_ready=1.
  - Response: 3 words, out_valid high in each completion cycle, in_ready never low.
- Partial flush:
  - Stimulus: beats 0x01,0x02, then flush.
  - Response: doutA=0x01020000, out_nbytes=2.
  - Stimulus: flush on the 4th beat.
  - Response: a single full word only.
- Blocked flush:
  - Stimulus: slot full with out_ready=0, 3 bytes packed, flush.
  - Response: flush pends, in_ready=0; after a drain the partial word appears with out_nbytes=3.
- Reset / overflow:
  - Stimulus: rstn low mid-word (cnt=2).
  - Response: all outputs 0, next word starts clean.
  - Stimulus: in_valid while in_ready=0.
  - Response: ovf=1 and remains set.
